// File: rtl/ann_pkg.sv
// ann_pkg: shared widths and FSM state type for the neuron MAC datapath.
package ann_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int N_IN   = 16;
    localparam int ACC_W  = 2*DATA_W+4;
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;
endpackage

// File: rtl/mac_sat.sv
// mac_sat: truncating shift of the biased sum, clamp to DATA_W, optional ReLU.
// Build option: define RELU_EN to clamp negative results to zero.
module mac_sat #(
    parameter int DATA_W = ann_pkg::DATA_W,
    parameter int FRAC_W = ann_pkg::FRAC_W,
    parameter int ACC_W  = ann_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0]  i_sum,
    output logic signed [DATA_W-1:0] o_result
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({(DATA_W-1){1'b1}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DATA_W-1:0] w_sat;
    always_comb begin
        w_shift = i_sum >>> FRAC_W;
        w_sat   = w_shift > SAT_MAX ? SAT_MAX[DATA_W-1:0] :
                  w_shift < SAT_MIN ? SAT_MIN[DATA_W-1:0] : w_shift[DATA_W-1:0];
`ifdef RELU_EN
        o_result = w_sat[DATA_W-1] ? '0 : w_sat;
`else
        o_result = w_sat;
`endif
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential N_IN-term multiply-accumulate neuron with bias and saturation.
// Build option: RELU_EN (handled in mac_sat).
module neuron_mac_seq #(
    parameter int DATA_W = ann_pkg::DATA_W,
    parameter int FRAC_W = ann_pkg::FRAC_W,
    parameter int N_IN   = ann_pkg::N_IN
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    output logic [3:0]               o_sel,
    input  logic signed [DATA_W-1:0] i_d,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [DATA_W-1:0] i_bias,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy
);
    localparam int ACC_W = 2*DATA_W+4;
    import ann_pkg::*;

    state_t                    r_state, w_next;
    logic [3:0]                r_sel;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_result;
    logic                      r_valid;
    logic                      w_last;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [DATA_W-1:0]  w_sat;

    always_comb begin
        w_last = r_sel == 4'(N_IN-1);
        w_prod = i_d * i_weight;
        w_sum  = r_acc + (ACC_W'(i_bias) <<< FRAC_W);
        w_next = r_state == IDLE  ? (i_start ? ACCUM : IDLE) :
                 r_state == ACCUM ? (w_last ? BIAS : ACCUM) :
                 r_state == BIAS  ? OUT : (i_ready ? IDLE : OUT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_sel <= '0;
                r_acc <= '0;
            end
            if (r_state == ACCUM) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_sel <= w_last ? '0 : r_sel + 4'd1;
            end
            if (r_state == BIAS) begin
                r_result <= w_sat;
                r_valid  <= 1'b1;
            end
            if (r_state == OUT && i_ready)
                r_valid <= 1'b0;
        end
    end

    mac_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_sat (
        .i_sum   (w_sum),
        .o_result(w_sat)
    );

    assign o_sel    = r_sel;
    assign o_result = r_result;
    assign o_valid  = r_valid;
    assign o_busy   = r_state != IDLE;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: table, random and hand-written sequence checks for neuron_mac_seq.
module tb_neuron_mac_seq;
    logic               i_clk = 1'b0;
    logic               i_rst, i_start, i_ready;
    logic [3:0]         o_sel;
    logic signed [15:0] i_d, i_weight, i_bias;
    logic signed [15:0] o_result;
    logic               o_valid, o_busy;
    logic signed [15:0] d_arr [16];
    logic signed [15:0] w_arr [16];
    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    assign i_d      = d_arr[o_sel];
    assign i_weight = w_arr[o_sel];

    neuron_mac_seq dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_sel(o_sel),
        .i_d(i_d), .i_weight(i_weight), .i_bias(i_bias), .o_result(o_result),
        .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    typedef struct {
        logic [15:0] d, w, b, exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic signed [15:0] b);
        longint s = 0;
        for (int k = 0; k < 16; k++) s += longint'(d_arr[k]) * longint'(w_arr[k]);
        s += longint'(b) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic fill(input logic [15:0] d, input logic [15:0] w);
        for (int k = 0; k < 16; k++) begin
            d_arr[k] = d;
            w_arr[k] = w;
        end
    endtask

    task automatic run_neuron(output logic [15:0] res, output int lat, output int sel_ok);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 0;
        sel_ok = 1;
        while (!o_valid && lat < 40) begin
            if (lat < 16 && o_sel != 4'(lat)) sel_ok = 0;
            if (lat == 16 && o_sel != 4'd0) sel_ok = 0;
            @(negedge i_clk);
            lat++;
        end
        res = o_result;
    endtask

    task automatic accept();
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("valid_drop", {31'd0, o_valid}, 32'd0);
        chk("busy_drop", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] res, hold_res, expv;
        int lat, sel_ok, guard;
        tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1000};
        tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
`ifdef RELU_EN
        tbl[2] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        tbl[3] = '{16'h0100, 16'hFF00, 16'h0200, 16'h0000};
        tbl[6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
`else
        tbl[2] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
        tbl[3] = '{16'h0100, 16'hFF00, 16'h0200, 16'hF200};
        tbl[6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
`endif
        tbl[4] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        tbl[5] = '{16'h0080, 16'h0080, 16'h0001, 16'h0401};
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_bias = '0;
        fill(16'h0, 16'h0);
        repeat (2) @(negedge i_clk);
        chk("rst_sel", {28'd0, o_sel}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_result", {16'd0, o_result}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int t = 0; t < 7; t++) begin
            fill(tbl[t].d, tbl[t].w);
            i_bias = tbl[t].b;
            run_neuron(res, lat, sel_ok);
            chk($sformatf("tbl%0d_result", t), {16'd0, res}, {16'd0, tbl[t].exp});
            chk($sformatf("tbl%0d_latency", t), lat, 17);
            chk($sformatf("tbl%0d_sel_steps", t), sel_ok, 1);
            accept();
        end

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 16; k++) begin
                d_arr[k] = 16'($urandom);
                w_arr[k] = (r < 4) ? 16'($urandom_range(0, 16'h03FF) - 16'h0200) : 16'($urandom);
            end
            i_bias = 16'($urandom);
            expv = model(i_bias);
            run_neuron(res, lat, sel_ok);
            chk($sformatf("rand%0d_result", r), {16'd0, res}, {16'd0, expv});
            chk($sformatf("rand%0d_latency", r), lat, 17);
            accept();
        end

        fill(16'h0100, 16'h0100);
        i_bias = '0;
        run_neuron(res, lat, sel_ok);
        hold_res = o_result;
        for (int c = 0; c < 5; c++) begin
            i_start = c[0];
            @(negedge i_clk);
            chk($sformatf("hold%0d_valid", c), {31'd0, o_valid}, 32'd1);
            chk($sformatf("hold%0d_result", c), {16'd0, o_result}, {16'd0, hold_res});
            chk($sformatf("hold%0d_busy", c), {31'd0, o_busy}, 32'd1);
        end
        i_start = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_ready = 1'b0;
        chk("handshake_valid", {31'd0, o_valid}, 32'd0);
        chk("handshake_start_ignored", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        chk("idle_after_handshake", {31'd0, o_busy}, 32'd0);

        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        guard = 0;
        while (o_sel != 4'd7 && guard < 40) begin
            @(negedge i_clk);
            guard++;
        end
        chk("reach_sel7", {31'd0, guard < 40}, 32'd1);
        i_rst = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        chk("midrst_sel", {28'd0, o_sel}, 32'd0);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        run_neuron(res, lat, sel_ok);
        chk("after_rst_result", {16'd0, res}, 32'h1000);
        chk("after_rst_latency", lat, 17);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
